// File: rtl/bbc_bus_sched_pkg.sv
// BBC bus scheduler shared types.
// State encoding, timeout width and abort data.
package bbc_bus_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADR,
    ST_DAT
  } state_t;

  localparam int TO_W = 8;

  localparam logic [7:0] ABORT_DATA = 8'hFF;

endpackage

// File: rtl/bbc_bus_sched_phi0_sync.sv
// bbc_phi0 synchroniser into hsclk.
// Produces the synced level and one-cycle rise/fall strobes.
module phi0_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic hsclk,
  input  logic resetb,
  input  logic bbc_phi0,
  output logic rise,
  output logic fall,
  output logic phi0_s
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   phi0_s_d;

  // shift phi0 through the sync chain, keep one delayed copy
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      sync     <= '0;
      phi0_s_d <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], bbc_phi0};
      phi0_s_d <= sync[SYNC_STAGES-1];
    end
  end

  assign phi0_s = sync[SYNC_STAGES-1];
  assign fall   = phi0_s_d & ~phi0_s;
  assign rise   = ~phi0_s_d & phi0_s;

endmodule

// File: rtl/bbc_bus_sched.sv
// CPU to 2MHz BBC bus access scheduler.
// One posted write buffer, reads stall the CPU until data returns.
module bbc_bus_sched
  import bbc_bus_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        hsclk,
  input  logic        resetb,
  input  logic        bbc_phi0,
  input  logic        req,
  input  logic        req_rnw,
  input  logic [15:0] req_adr,
  input  logic [7:0]  req_data,
  output logic        ack,
  output logic [7:0]  rd_data,
  output logic        cpu_hold,
  output logic        bbc_own,
  output logic [15:0] bbc_adr_o,
  output logic        bbc_rnw_o,
  output logic [7:0]  bbc_data_o,
  output logic        bbc_data_oe,
  input  logic [7:0]  bbc_data_i,
  output logic        wbuf_full,
  output logic        timeout,
  input  logic        timeout_clr
);

  state_t            state;
  state_t            state_nx;
  logic              rise;
  logic              fall;
  logic              phi0_s;
  logic [TO_W-1:0]   tcnt;
  logic [15:0]       wb_adr;
  logic [7:0]        wb_data;
  logic              cur_rnw;
  logic              kind;
  logic              wr_acc;
  logic              rd_pend;
  logic              pend;
  logic              more;
  logic              to_hit;
  logic              done;
  logic              abort;

  phi0_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .hsclk   (hsclk),
    .resetb  (resetb),
    .bbc_phi0(bbc_phi0),
    .rise    (rise),
    .fall    (fall),
    .phi0_s  (phi0_s)
  );

  assign wr_acc  = req & ~req_rnw & ~wbuf_full & ~ack;
  assign rd_pend = req & req_rnw & ~ack;
  assign pend    = wbuf_full | rd_pend;
  assign to_hit  = (tcnt == TO_W'(TIMEOUT_CYC - 1));
  assign kind    = (state == ST_ALIGN) ? ~wbuf_full : cur_rnw;
  assign more    = cur_rnw ? wbuf_full : rd_pend;

  // next state: edges move the access on, a stuck state aborts
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    abort    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pend) state_nx = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (fall) state_nx = ST_ADR;
        else if (to_hit) abort = 1'b1;
      end
      ST_ADR: begin
        if (rise) state_nx = ST_DAT;
        else if (to_hit) abort = 1'b1;
      end
      ST_DAT: begin
        if (fall) begin
          done     = 1'b1;
          state_nx = more ? ST_ADR : ST_IDLE;
        end else if (to_hit) begin
          abort = 1'b1;
        end
      end
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  // state register and per-state dwell counter
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || state_nx == ST_IDLE)
        tcnt <= '0;
      else
        tcnt <= tcnt + TO_W'(1);
    end
  end

  // pick which access the next bus cycle serves; writes go first
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      cur_rnw <= 1'b0;
    end else if (state_nx == ST_ADR && state != ST_ADR) begin
      cur_rnw <= (state == ST_DAT) ? ~cur_rnw : ~wbuf_full;
    end
  end

  // posted write buffer: fill on accept, empty on drain or abort
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      wbuf_full <= 1'b0;
      wb_adr    <= '0;
      wb_data   <= '0;
    end else if (wr_acc) begin
      wbuf_full <= 1'b1;
      wb_adr    <= req_adr;
      wb_data   <= req_data;
    end else if ((done | abort) & ~kind) begin
      wbuf_full <= 1'b0;
    end
  end

  // CPU handshake: ack pulse and read data return
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      ack     <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      ack <= wr_acc | ((done | abort) & kind);
      if (done & kind)
        rd_data <= bbc_data_i;
      else if (abort & kind)
        rd_data <= ABORT_DATA;
    end
  end

  // sticky abort flag, a new abort beats a clear
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb)
      timeout <= 1'b0;
    else if (abort)
      timeout <= 1'b1;
    else if (timeout_clr)
      timeout <= 1'b0;
  end

  assign bbc_own     = (state == ST_ADR) | (state == ST_DAT);
  assign bbc_adr_o   = bbc_own ? (cur_rnw ? req_adr : wb_adr) : 16'h0000;
  assign bbc_rnw_o   = bbc_own ? cur_rnw : 1'b1;
  assign bbc_data_oe = (state == ST_DAT) & ~cur_rnw & phi0_s;
  assign bbc_data_o  = bbc_data_oe ? wb_data : 8'h00;
  assign cpu_hold    = resetb & req & ~ack & (req_rnw | wbuf_full);

endmodule
